micro_seq_core: RTL and testbench

//  Parametrised successor of the fixed-program FSM datapath: a single-issue micro-sequencer.

---
 rtl/micro_seq_pkg.sv | 39 +++
 rtl/micro_seq_if.sv | 27 ++
 rtl/micro_seq_regfile.sv | 34 +++
 rtl/micro_seq_core.sv | 130 +++++++++++++
 tb/tb_micro_seq_core.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_seq_pkg.sv
// Shared types for the micro-sequencer: opcodes, FSM states, instruction field
// positions and an instruction encoder.
package micro_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_SUBI = 3'd3,
    OP_LI   = 3'd4,
    OP_NOP  = 3'd5,
    OP_JMP  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  localparam int RD_LSB  = 0;
  localparam int RD_MSB  = 3;
  localparam int RS2_LSB = 4;
  localparam int RS2_MSB = 7;
  localparam int RS1_LSB = 8;
  localparam int RS1_MSB = 11;
  localparam int OP_LSB  = 12;
  localparam int OP_MSB  = 14;
  localparam int IMM_LSB = 15;
  localparam int IMM_MSB = 31;

  function automatic logic [31:0] mk_inst(input op_e op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2,
                                          input logic [16:0] imm);
    return {imm, op, rs1, rs2, rd};
  endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Program-load and register read-out channels of the micro-sequencer.
// master = driver of requests (harness), slave = the core.
interface micro_seq_if #(
  parameter int AW   = 4,
  parameter int XLEN = 32
);
  logic            load_valid;
  logic            load_ready;
  logic [AW-1:0]   load_addr;
  logic [31:0]     load_data;
  logic            rd_addr_valid;
  logic            rd_addr_ready;
  logic [3:0]      rd_addr_bits;
  logic            rd_data_valid;
  logic            rd_data_ready;
  logic [XLEN-1:0] rd_data_bits;

  modport master (
    output load_valid, load_addr, load_data, rd_addr_valid, rd_addr_bits, rd_data_ready,
    input  load_ready, rd_addr_ready, rd_data_valid, rd_data_bits
  );

  modport slave (
    input  load_valid, load_addr, load_data, rd_addr_valid, rd_addr_bits, rd_data_ready,
    output load_ready, rd_addr_ready, rd_data_valid, rd_data_bits
  );
endinterface

// File: rtl/micro_seq_regfile.sv
// NREGS x XLEN register file: three combinational read ports, one synchronous
// write port. Register fields are 4 bits wide and taken modulo NREGS.
module micro_seq_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [3:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [3:0]      i_ra1,
  input  logic [3:0]      i_ra2,
  input  logic [3:0]      i_ra3,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  output logic [XLEN-1:0] o_rd3
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] r_mem [NREGS];

  function automatic logic [RW-1:0] idx(input logic [3:0] a);
    return RW'(32'(a) % NREGS);
  endfunction

  always_ff @(posedge clk) begin
    if (i_we) r_mem[idx(i_waddr)] <= i_wdata;
  end

  assign o_rd1 = r_mem[idx(i_ra1)];
  assign o_rd2 = r_mem[idx(i_ra2)];
  assign o_rd3 = r_mem[idx(i_ra3)];

endmodule

// File: rtl/micro_seq_core.sv
// Single-issue micro-sequencer: run-time loadable imem, IDLE/RUN/HALTED FSM,
// retired counter and a one-entry register read-out response buffer.
// Optional MICRO_SEQ_STEP_EN adds a `step` input gating execution in RUN.
module micro_seq_core
  import micro_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 16,
  parameter int IMEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef MICRO_SEQ_STEP_EN
  input  logic        step,
`endif
  output logic        busy,
  output logic        halted,
  output logic [31:0] retired,
  micro_seq_if.slave  bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic [31:0]     r_retired;
  logic [31:0]     r_imem [IMEM_DEPTH];
  logic [31:0]     w_inst;
  op_e             w_op;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_rd_val, w_wdata;
  logic            w_we, w_exec, w_start_ok, w_load_en, w_rd_acc;
  logic            r_rd_valid;
  logic [XLEN-1:0] r_rd_data;

  assign w_inst     = r_imem[r_pc];
  assign w_op       = op_e'(w_inst[OP_MSB:OP_LSB]);
  assign w_imm      = XLEN'(w_inst[IMM_MSB:IMM_LSB]);
  assign w_start_ok = start && (r_state != RUN);
`ifdef MICRO_SEQ_STEP_EN
  assign w_exec     = (r_state == RUN) && step;
`else
  assign w_exec     = (r_state == RUN);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = AW'(r_pc + 1'b1);
    w_we        = 1'b0;
    w_wdata     = '0;
    case (r_state)
      IDLE, HALTED: if (start) w_state_nxt = RUN;
      RUN: begin
        if (w_exec) begin
          case (w_op)
            OP_ADD:  begin w_we = 1'b1; w_wdata = w_rs1_val + w_rs2_val; end
            OP_SUB:  begin w_we = 1'b1; w_wdata = w_rs1_val - w_rs2_val; end
            OP_ADDI: begin w_we = 1'b1; w_wdata = w_rs1_val + w_imm; end
            OP_SUBI: begin w_we = 1'b1; w_wdata = w_rs1_val - w_imm; end
            OP_LI:   begin w_we = 1'b1; w_wdata = w_imm; end
            OP_NOP:  ;
            OP_JMP:  w_pc_nxt = w_imm[AW-1:0];
            OP_HALT: begin w_state_nxt = HALTED; w_pc_nxt = r_pc; end
          endcase
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // HALT leaves pc on the HALT word and is not counted as retired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_retired <= '0;
    end else if (w_start_ok) begin
      r_pc <= '0;
    end else if (w_exec) begin
      r_pc <= w_pc_nxt;
      if (w_op != OP_HALT) r_retired <= r_retired + 32'd1;
    end
  end

  assign w_load_en = bus.load_valid && (r_state != RUN);

  always_ff @(posedge clk) begin
    if (w_load_en) r_imem[bus.load_addr] <= bus.load_data;
  end

  micro_seq_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_inst[RD_MSB:RD_LSB]),
    .i_wdata (w_wdata),
    .i_ra1   (w_inst[RS1_MSB:RS1_LSB]),
    .i_ra2   (w_inst[RS2_MSB:RS2_LSB]),
    .i_ra3   (bus.rd_addr_bits),
    .o_rd1   (w_rs1_val),
    .o_rd2   (w_rs2_val),
    .o_rd3   (w_rd_val)
  );

  // Read-out samples the register before this edge's write: no forwarding
  assign w_rd_acc = bus.rd_addr_valid && bus.rd_addr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_rd_acc) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_val;
    end else if (bus.rd_data_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign bus.rd_addr_ready = !r_rd_valid || bus.rd_data_ready;
  assign bus.rd_data_valid = r_rd_valid;
  assign bus.rd_data_bits  = r_rd_data;
  assign bus.load_ready    = (r_state != RUN);
  assign busy              = (r_state == RUN);
  assign halted            = (r_state == HALTED);
  assign retired           = r_retired;

endmodule

// File: tb/tb_micro_seq_core.sv
// Directed bench for micro_seq_core: a default-depth instance and an
// IMEM_DEPTH=4 instance driven through their own interfaces.
module tb_micro_seq_core;
  import micro_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
`ifdef MICRO_SEQ_STEP_EN
  logic        step;
`endif
  logic        busy, halted, busy4, halted4;
  logic [31:0] retired, retired4;
  int          errors = 0;
  int          checks = 0;

  micro_seq_if #(.AW(4), .XLEN(32)) bus  ();
  micro_seq_if #(.AW(2), .XLEN(32)) bus4 ();

  micro_seq_core u_dut (
    .clk     (clk),
    .reset   (rst),
    .start   (start),
`ifdef MICRO_SEQ_STEP_EN
    .step    (step),
`endif
    .busy    (busy),
    .halted  (halted),
    .retired (retired),
    .bus     (bus.slave)
  );

  micro_seq_core #(.IMEM_DEPTH(4)) u_d4 (
    .clk     (clk),
    .reset   (rst),
    .start   (start4),
`ifdef MICRO_SEQ_STEP_EN
    .step    (step),
`endif
    .busy    (busy4),
    .halted  (halted4),
    .retired (retired4),
    .bus     (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [3:0] a, input logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic ld4(input logic [1:0] a, input logic [31:0] d);
    bus4.load_valid = 1'b1;
    bus4.load_addr  = a;
    bus4.load_data  = d;
    tick();
    bus4.load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
`ifdef MICRO_SEQ_STEP_EN
    step = 1'b1;
`endif
    bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.rd_addr_valid = 1'b0; bus.rd_addr_bits = '0; bus.rd_data_ready = 1'b1;
    bus4.load_valid = 1'b0; bus4.load_addr = '0; bus4.load_data = '0;
    bus4.rd_addr_valid = 1'b0; bus4.rd_addr_bits = '0; bus4.rd_data_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_rdvalid", bus.rd_data_valid, 0);
    chk("rst_rdbits", bus.rd_data_bits, 0);
    chk("rst_loadready", bus.load_ready, 1);
    rst = 1'b0;
    tick();

    // Program 1: LI r1,5; LI r2,3; SUB r3,r1,r2; HALT
    ld(0, mk_inst(OP_LI, 4'd1, 4'd0, 4'd0, 17'd5));
    ld(1, mk_inst(OP_LI, 4'd2, 4'd0, 4'd0, 17'd3));
    ld(2, mk_inst(OP_SUB, 4'd3, 4'd1, 4'd2, 17'd0));
    ld(3, mk_inst(OP_HALT, 4'd0, 4'd0, 4'd0, 17'd0));
    start = 1'b1; tick(); start = 1'b0;
    chk("p1_busy", busy, 1);
    chk("p1_loadready_run", bus.load_ready, 0);
    tick(); tick(); tick();
    chk("p1_busy3", busy, 1);
    chk("p1_retired3", retired, 3);
    tick();
    chk("p1_halted", halted, 1);
    chk("p1_notbusy", busy, 0);
    chk("p1_retired", retired, 3);
    bus.rd_addr_valid = 1'b1; bus.rd_addr_bits = 4'd3;
    tick();
    bus.rd_addr_valid = 1'b0;
    chk("p1_r3_valid", bus.rd_data_valid, 1);
    chk("p1_r3", bus.rd_data_bits, 2);
    tick();
    chk("p1_r3_drop", bus.rd_data_valid, 0);

    // Back-pressure: response held for 5 cycles, then two back-to-back reads
    bus.rd_data_ready = 1'b0;
    bus.rd_addr_valid = 1'b1; bus.rd_addr_bits = 4'd1;
    tick();
    bus.rd_addr_bits = 4'd2;
    for (int i = 0; i < 5; i++) begin
      chk("hold_addrready", bus.rd_addr_ready, 0);
      chk("hold_valid", bus.rd_data_valid, 1);
      chk("hold_data", bus.rd_data_bits, 5);
      tick();
    end
    bus.rd_data_ready = 1'b1;
    #1;
    chk("rel_addrready", bus.rd_addr_ready, 1);
    tick();
    chk("b2b_r2", bus.rd_data_bits, 3);
    bus.rd_addr_bits = 4'd1;
    tick();
    chk("b2b_r1", bus.rd_data_bits, 5);
    chk("b2b_valid", bus.rd_data_valid, 1);
    bus.rd_addr_valid = 1'b0;
    tick();
    chk("b2b_drop", bus.rd_data_valid, 0);

    // Program 2: LI r1,1; ADD r1,r1,r1; JMP 1 -- ADDs land on even RUN cycles
    ld(0, mk_inst(OP_LI, 4'd1, 4'd0, 4'd0, 17'd1));
    ld(1, mk_inst(OP_ADD, 4'd1, 4'd1, 4'd1, 17'd0));
    ld(2, mk_inst(OP_JMP, 4'd0, 4'd0, 4'd0, 17'd1));
    start = 1'b1; tick(); start = 1'b0;
    repeat (18) tick();
    chk("p2_busy", busy, 1);
    chk("p2_loadready", bus.load_ready, 0);
    chk("p2_retired18", retired, 3 + 18);
    bus.rd_addr_valid = 1'b1; bus.rd_addr_bits = 4'd1;
    tick();
    bus.rd_addr_valid = 1'b0; bus.rd_data_ready = 1'b0;
    chk("p2_r1", bus.rd_data_bits, 512);
    chk("p2_retired19", retired, 3 + 19);

    // Asynchronous reset mid-RUN with a response pending
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rdvalid", bus.rd_data_valid, 0);
    chk("arst_retired", retired, 0);
    #1 rst = 1'b0;
    bus.rd_data_ready = 1'b1;
    tick();
    ld(2, mk_inst(OP_HALT, 4'd0, 4'd0, 4'd0, 17'd0));
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("rerun_halted", halted, 1);
    chk("rerun_retired", retired, 2);
    bus.rd_addr_valid = 1'b1; bus.rd_addr_bits = 4'd1;
    tick();
    bus.rd_addr_valid = 1'b0;
    chk("rerun_r1", bus.rd_data_bits, 2);

    // Program 3: load+start same cycle, read r4 while LI r4,9 retires
    ld(1, mk_inst(OP_LI, 4'd4, 4'd0, 4'd0, 17'd9));
    ld(2, mk_inst(OP_HALT, 4'd0, 4'd0, 4'd0, 17'd0));
    bus.load_valid = 1'b1; bus.load_addr = 4'd0;
    bus.load_data = mk_inst(OP_LI, 4'd4, 4'd0, 4'd0, 17'd6);
    start = 1'b1; tick(); start = 1'b0; bus.load_valid = 1'b0;
    tick();
    bus.rd_addr_valid = 1'b1; bus.rd_addr_bits = 4'd4;
    tick();
    chk("r4_old", bus.rd_data_bits, 6);
    tick();
    chk("r4_new", bus.rd_data_bits, 9);
    chk("p3_halted", halted, 1);
    chk("p3_retired", retired, 4);
    bus.rd_addr_valid = 1'b0;
    tick();

    // Depth-4 instance: seed r1=0, then ADDI r1,r1,1 + three NOPs, no HALT
    ld4(0, mk_inst(OP_LI, 4'd1, 4'd0, 4'd0, 17'd0));
    ld4(1, mk_inst(OP_HALT, 4'd0, 4'd0, 4'd0, 17'd0));
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick(); tick();
    chk("d4_seed_halted", halted4, 1);
    chk("d4_seed_retired", retired4, 1);
    ld4(0, mk_inst(OP_ADDI, 4'd1, 4'd1, 4'd0, 17'd1));
    ld4(1, mk_inst(OP_NOP, 4'd0, 4'd0, 4'd0, 17'd0));
    ld4(2, mk_inst(OP_NOP, 4'd0, 4'd0, 4'd0, 17'd0));
    ld4(3, mk_inst(OP_NOP, 4'd0, 4'd0, 4'd0, 17'd0));
    start4 = 1'b1; tick(); start4 = 1'b0;
    repeat (8) tick();
    chk("d4_retired8", retired4, 9);
    chk("d4_busy", busy4, 1);
    bus4.rd_addr_valid = 1'b1; bus4.rd_addr_bits = 4'd1;
    tick();
    chk("d4_r1_wrap", bus4.rd_data_bits, 2);
    chk("d4_retired9", retired4, 10);
    tick();
    chk("d4_r1_next", bus4.rd_data_bits, 3);
    bus4.rd_addr_valid = 1'b0;

`ifdef MICRO_SEQ_STEP_EN
    // Step gating: no progress with step low, one instruction per pulse
    ld(2, mk_inst(OP_NOP, 4'd0, 4'd0, 4'd0, 17'd0));
    ld(3, mk_inst(OP_HALT, 4'd0, 4'd0, 4'd0, 17'd0));
    step = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("step_frozen", retired, 4);
    chk("step_busy", busy, 1);
    repeat (3) begin
      step = 1'b1; tick(); step = 1'b0; tick();
    end
    chk("step_retired", retired, 7);
    chk("step_still_busy", busy, 1);
    step = 1'b1; tick();
    chk("step_halted", halted, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
